// File: rtl/irq_pending_ctrl.sv
// Sticky request capture with mask, fixed-priority selection (bit 3 highest) and a
// valid/ready presentation stage that clears the accepted pending bit.
module irq_pending_ctrl #(
   parameter int EDGE = 1,
   parameter int N    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   out_idx,
   output logic [N-1:0] pending,
   output logic [N-1:0] lost
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [N-1:0]   pending_r;
   logic [N-1:0]   req_q_r;
   logic [N-1:0]   lost_r;
   logic           out_valid_r;
   logic [1:0]     out_idx_r;

   logic [N-1:0]   set_s;
   logic [N-1:0]   clr_s;
   logic [N-1:0]   active_s;
   logic [N-1:0]   pend_nxt_s;
   logic [N-1:0]   lost_nxt_s;
   logic           valid_nxt_s;
   logic [1:0]     idx_nxt_s;

   function automatic logic [1:0] enc_prio(input logic [N-1:0] v);
      if (v[3]) begin
         return 2'd3;
      end else if (v[2]) begin
         return 2'd2;
      end else if (v[1]) begin
         return 2'd1;
      end else begin
         return 2'd0;
      end
   endfunction

   function automatic logic [N-1:0] onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0010;
         2'd2:    return 4'b0100;
         2'd3:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // Request events, acceptance clear and next pending/lost values
   always_comb begin
      if (EDGE != 0) begin
         set_s = req & ~req_q_r;
      end else begin
         set_s = req;
      end
      if (out_valid_r && out_ready) begin
         clr_s = onehot(out_idx_r);
      end else begin
         clr_s = 4'b0000;
      end
      active_s = pending_r & ~mask;
      // set is OR'ed after the clear so a same-cycle re-arrival keeps the bit pending
      if (flush) begin
         pend_nxt_s = 4'b0000;
         lost_nxt_s = 4'b0000;
      end else begin
         pend_nxt_s = (pending_r & ~clr_s) | set_s;
         lost_nxt_s = set_s & pending_r & ~clr_s;
      end
   end

   // Pending bits, request history and lost-event pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_r <= 4'b0000;
         req_q_r   <= 4'b0000;
         lost_r    <= 4'b0000;
      end else begin
         pending_r <= pend_nxt_s;
         req_q_r   <= req;
         lost_r    <= lost_nxt_s;
      end
   end

   // Presentation state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Presentation next state; no preemption once an index is presented
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if ((|active_s) && !flush) begin
               state_nxt_s = PRESENT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PRESENT: begin
            if (flush || out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = PRESENT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Presentation outputs: index captured only on the IDLE -> PRESENT transition
   always_comb begin
      valid_nxt_s = (state_nxt_s == PRESENT);
      if ((state_r == IDLE) && (state_nxt_s == PRESENT)) begin
         idx_nxt_s = enc_prio(active_s);
      end else begin
         idx_nxt_s = out_idx_r;
      end
   end

   // Registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_idx_r   <= 2'd0;
      end else begin
         out_valid_r <= valid_nxt_s;
         out_idx_r   <= idx_nxt_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_idx   = out_idx_r;
   assign pending   = pending_r;
   assign lost      = lost_r;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_irq_pending_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] mask;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_idx;
   logic [3:0] pending;
   logic [3:0] lost;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // behavioural model state
   logic [3:0] m_pend  = 4'b0000;
   logic [3:0] m_prev  = 4'b0000;
   logic [3:0] m_lost  = 4'b0000;
   bit         m_valid = 1'b0;
   logic [1:0] m_idx   = 2'd0;

   irq_pending_ctrl #(.EDGE(1), .N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .pending   (pending),
      .lost      (lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] highest(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   // model: apply the documented rules to the inputs seen at each rising edge
   always @(posedge clk) begin
      logic [3:0] ev;
      logic [3:0] taken;
      logic [3:0] avail;
      if (!rst_n) begin
         m_pend  = 4'b0000;
         m_prev  = 4'b0000;
         m_lost  = 4'b0000;
         m_valid = 1'b0;
         m_idx   = 2'd0;
      end else begin
         ev    = req & ~m_prev;
         taken = 4'b0000;
         if (m_valid && out_ready) taken[m_idx] = 1'b1;
         avail = m_pend & ~mask;
         if (m_valid) begin
            if (flush || out_ready) m_valid = 1'b0;
         end else if (avail != 4'b0000 && !flush) begin
            m_valid = 1'b1;
            m_idx   = highest(avail);
         end
         m_lost = flush ? 4'b0000 : (ev & m_pend & ~taken);
         m_pend = flush ? 4'b0000 : ((m_pend & ~taken) | ev);
         m_prev = req;
      end
   end

   // compare DUT against model every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", {3'b000, out_valid}, {3'b000, m_valid});
         check("m_pending", pending, m_pend);
         check("m_lost", lost, m_lost);
         if (m_valid) check("m_idx", {2'b00, out_idx}, {2'b00, m_idx});
      end
   end

   initial begin
      bit         ev3[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0] ei3[7] = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
      int         vcnt;
      logic [1:0] vidx;

      clk = 1'b0; rst_n = 1'b0; req = 4'b0000; mask = 4'b0000;
      flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1 chk_en = 1'b1;

      // 1: reset hold
      repeat (3) @(negedge clk);
      check("rst_valid", {3'b000, out_valid}, 4'd0);
      check("rst_idx", {2'b00, out_idx}, 4'd0);
      check("rst_pending", pending, 4'b0000);
      check("rst_lost", lost, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);

      // 2: single pulse, 2-cycle latency
      req = 4'b0010; out_ready = 1'b1;
      @(negedge clk); req = 4'b0000;
      check("t2_pend", pending, 4'b0010);
      check("t2_valid0", {3'b000, out_valid}, 4'd0);
      @(negedge clk);
      check("t2_valid1", {3'b000, out_valid}, 4'd1);
      check("t2_idx", {2'b00, out_idx}, 4'd1);
      @(negedge clk);
      check("t2_valid_after", {3'b000, out_valid}, 4'd0);
      check("t2_pend_after", pending, 4'b0000);

      // 3: three simultaneous requests drained in priority order
      req = 4'b1011;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         req = 4'b0000;
         check("t3_valid", {3'b000, out_valid}, {3'b000, ev3[k]});
         if (ev3[k]) check("t3_idx", {2'b00, out_idx}, {2'b00, ei3[k]});
      end
      check("t3_pend_end", pending, 4'b0000);

      // 4: backpressure, no preemption by a higher request
      out_ready = 1'b0; req = 4'b0010;
      @(negedge clk); req = 4'b0000;
      @(negedge clk);
      check("t4_valid", {3'b000, out_valid}, 4'd1);
      check("t4_idx", {2'b00, out_idx}, 4'd1);
      for (int i = 0; i < 5; i++) begin
         req = (i == 1) ? 4'b1000 : 4'b0000;
         @(negedge clk);
         check("t4_hold_idx", {2'b00, out_idx}, 4'd1);
      end
      req = 4'b0000; out_ready = 1'b1;
      @(negedge clk);
      check("t4_acc_valid", {3'b000, out_valid}, 4'd0);
      check("t4_acc_pend", pending, 4'b1000);
      @(negedge clk);
      check("t4_next_idx", {2'b00, out_idx}, 4'd3);
      @(negedge clk);
      check("t4_end_pend", pending, 4'b0000);

      // 5: masked pending is latched but not presented
      mask = 4'b1000; req = 4'b1000;
      @(negedge clk); req = 4'b0000;
      check("t5_pend", pending, 4'b1000);
      repeat (2) begin
         @(negedge clk);
         check("t5_masked_valid", {3'b000, out_valid}, 4'd0);
      end
      mask = 4'b0000;
      @(negedge clk);
      check("t5_unmask_valid", {3'b000, out_valid}, 4'd1);
      check("t5_unmask_idx", {2'b00, out_idx}, 4'd3);
      @(negedge clk);
      check("t5_end_pend", pending, 4'b0000);

      // 6: lost pulse, flush during PRESENT, reset with request held
      out_ready = 1'b0; req = 4'b0100;
      @(negedge clk); req = 4'b0000;
      @(negedge clk);
      check("t6_idx", {2'b00, out_idx}, 4'd2);
      req = 4'b0100;
      @(negedge clk); req = 4'b0000;
      check("t6_lost", lost, 4'b0100);
      @(negedge clk);
      check("t6_lost_gone", lost, 4'b0000);
      check("t6_pend", pending, 4'b0100);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      check("t6_flush_pend", pending, 4'b0000);
      check("t6_flush_valid", {3'b000, out_valid}, 4'd0);
      rst_n = 1'b0; req = 4'b0001; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0; vidx = 2'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) begin
            vcnt++;
            vidx = out_idx;
         end
      end
      check("t6_once_cnt", 4'(vcnt), 4'd1);
      check("t6_once_idx", {2'b00, vidx}, 4'd0);
      req = 4'b0000;

      // randomized traffic, checked by the model process
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req       = 4'($urandom) & 4'($urandom);
         if ($urandom_range(7, 0) == 0) mask = 4'($urandom);
         out_ready = 1'($urandom);
         flush     = ($urandom_range(39, 0) == 0);
         rst_n     = ($urandom_range(299, 0) != 0);
      end
      req = 4'b0000; flush = 1'b0; rst_n = 1'b1; mask = 4'b0000; out_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("drain_pend", pending, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
